// File: rtl/simple_latch.sv
// rtl/simple_latch.sv - enable-gated holding register, sync active-high reset; optional SIMPLE_LATCH_CHECK_EN input checks
module simple_latch #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b
);

   logic [WIDTH-1:0] held;

   // Single storage register: reset has priority, then capture on enable, else hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         held <= RESET_VALUE;
      end else if (enable) begin
         held <= a;
      end
   end

   assign b = held;

`ifdef SIMPLE_LATCH_CHECK_EN
   // Flag undriven or unknown control/data at capture time; never touches the register.
   always @(posedge clock) begin
      if (reset === 1'b0) begin
         if ($isunknown(enable)) begin
            $error("simple_latch: enable is X/Z at rising edge");
         end else if (enable === 1'b1 && $isunknown(a)) begin
            $error("simple_latch: a has X/Z bits while enable=1");
         end
      end
   end
`else
   // Checks compiled out: purely synthesisable register only.
`endif

endmodule

// File: tb/tb_simple_latch.sv
// tb/tb_simple_latch.sv - directed self-checking bench for simple_latch (1-bit and 8-bit instances)
module tb_simple_latch;

   logic       clock;
   logic       reset1;
   logic       enable1;
   logic [0:0] a1;
   logic [0:0] b1;

   logic       reset8;
   logic       enable8;
   logic [7:0] a8;
   logic [7:0] b8;

   int checks;
   int errors;

   simple_latch #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_dut1 (
      .clock  (clock),
      .reset  (reset1),
      .enable (enable1),
      .a      (a1),
      .b      (b1)
   );

   simple_latch #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clock  (clock),
      .reset  (reset8),
      .enable (enable8),
      .a      (a8),
      .b      (b8)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance past the next rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset1 = 1'b1; enable1 = 1'b0; a1 = 1'b0;
      tick();
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_basic: b=%b expected=%b", b1, 1'b0);
      end
      enable1 = 1'b1; a1 = 1'b1;
      tick();
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority: b=%b expected=%b", b1, 1'b0);
      end
   endtask

   task automatic test_capture();
      logic [5:0] pattern;
      pattern = 6'b010101;  // bit i is driven on cycle i: 1,0,1,0,1,0
      reset1 = 1'b0; enable1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a1 = pattern[i];
         tick();
         checks++;
         if (b1 !== pattern[i]) begin
            errors++;
            $display("FAIL capture[%0d]: b=%b expected=%b", i, b1, pattern[i]);
         end
      end
   endtask

   task automatic test_hold();
      reset1 = 1'b0; enable1 = 1'b1; a1 = 1'b1;
      tick();
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL hold_load: b=%b expected=%b", b1, 1'b1);
      end
      enable1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a1 = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         checks++;
         if (b1 !== 1'b1) begin
            errors++;
            $display("FAIL hold[%0d]: b=%b expected=%b", i, b1, 1'b1);
         end
      end
      enable1 = 1'b1; a1 = 1'b0;
      tick();
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL hold_reenable: b=%b expected=%b", b1, 1'b0);
      end
   endtask

   task automatic test_mid_reset();
      reset1 = 1'b0; enable1 = 1'b1; a1 = 1'b1;
      tick();
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: b=%b expected=%b", b1, 1'b1);
      end
      reset1 = 1'b1;
      tick();
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: b=%b expected=%b", b1, 1'b0);
      end
      reset1 = 1'b0;
      tick();
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL midreset_release: b=%b expected=%b", b1, 1'b1);
      end
   endtask

   task automatic test_between_edges();
      // Hold a known 0, then pulse enable/a between edges only.
      reset1 = 1'b0; enable1 = 1'b1; a1 = 1'b0;
      tick();
      enable1 = 1'b0;
      tick();
      enable1 = 1'b1; a1 = 1'b1;
      #2;
      enable1 = 1'b0; a1 = 1'b0;
      #1;
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL between_edges_mid: b=%b expected=%b", b1, 1'b0);
      end
      tick();
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL between_edges_after: b=%b expected=%b", b1, 1'b0);
      end
   endtask

   task automatic test_width();
      reset8 = 1'b1; enable8 = 1'b0; a8 = 8'h00;
      tick();
      checks++;
      if (b8 !== 8'hA5) begin
         errors++;
         $display("FAIL width_reset: b=%h expected=%h", b8, 8'hA5);
      end
      reset8 = 1'b0; enable8 = 1'b1; a8 = 8'h3C;
      tick();
      checks++;
      if (b8 !== 8'h3C) begin
         errors++;
         $display("FAIL width_capture: b=%h expected=%h", b8, 8'h3C);
      end
      enable8 = 1'b0; a8 = 8'hFF;
      tick();
      checks++;
      if (b8 !== 8'h3C) begin
         errors++;
         $display("FAIL width_hold: b=%h expected=%h", b8, 8'h3C);
      end
      reset8 = 1'b1; enable8 = 1'b1; a8 = 8'h5A;
      tick();
      checks++;
      if (b8 !== 8'hA5) begin
         errors++;
         $display("FAIL width_reset_priority: b=%h expected=%h", b8, 8'hA5);
      end
      reset8 = 1'b0;
      tick();
      checks++;
      if (b8 !== 8'h5A) begin
         errors++;
         $display("FAIL width_release_enabled: b=%h expected=%h", b8, 8'h5A);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vec [4];
      vec[0] = 8'h01; vec[1] = 8'h80; vec[2] = 8'hFE; vec[3] = 8'h7F;
      reset8 = 1'b0; enable8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a8 = vec[i];
         tick();
         checks++;
         if (b8 !== vec[i]) begin
            errors++;
            $display("FAIL back_to_back[%0d]: b=%h expected=%h", i, b8, vec[i]);
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset1  = 1'b1; enable1 = 1'b0; a1 = 1'b0;
      reset8  = 1'b1; enable8 = 1'b0; a8 = 8'h00;
      #2;
      test_reset();
      test_capture();
      test_hold();
      test_mid_reset();
      test_between_edges();
      test_width();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
